// File: rtl/dandy_pkg.sv
// Shared definitions for the dandy_dance display animator: segment bit
// constants, the 2-bit pattern codes and the frame ROM.
package dandy_pkg;

    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;
    localparam logic [6:0] SEG_G = 7'h40;

    typedef enum logic [1:0] {
        PAT_SPIN   = 2'd0,
        PAT_BOUNCE = 2'd1,
        PAT_WIGGLE = 2'd2,
        PAT_PULSE  = 2'd3
    } pat_e;

    // Ascending ranges so the leftmost group is pattern 0 and, inside each
    // group, the leftmost entry is frame 0.
    localparam logic [0:3][0:7][6:0] SEG_ROM = {
        {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_A, SEG_B},             // spin
        {SEG_A, SEG_G, SEG_D, SEG_G, SEG_A, SEG_G, SEG_D, SEG_G},             // bounce
        {7'h30, 7'h06, 7'h30, 7'h06, 7'h36, 7'h00, 7'h36, 7'h00},             // wiggle
        {7'h00, 7'h08, 7'h5C, 7'h63, 7'h7F, 7'h63, 7'h5C, 7'h08}              // pulse
    };

    function automatic logic [6:0] seg_lookup(input pat_e pat, input logic [2:0] frame);
        return SEG_ROM[pat][frame];
    endfunction

endpackage

// File: rtl/dandy_dance_if.sv
// Pin bundle of the Tiny Tapeout user tile: selection, dedicated inputs and
// outputs, and the bidirectional uio group.
interface dandy_dance_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Driver side (harness or chip pads).
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // Design side.
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/dandy_tempo.sv
// Step prescaler: counts enabled clocks and emits a one-cycle tick every
// max(1, BASE_DIV >> speed) enabled clocks.
module dandy_tempo #(
    parameter int BASE_DIV = 1 << 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam int DIV   = (BASE_DIV < 1) ? 1 : BASE_DIV;
    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit_m1;
    logic [31:0]      shifted;

    // Terminal count for the selected speed; the >= compare lets a count left
    // over-range by a speed change tick immediately instead of wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        shifted  = 32'(DIV) >> speed;
        limit_m1 = (shifted > 32'd1) ? CNT_W'(shifted - 32'd1) : '0;
        tick     = enable && (cnt_q >= limit_m1);
        cnt_d    = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register; holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dandy_dance.sv
// Tiny Tapeout top: steps one of four 8-frame dance routines on a 7-segment
// display and exports frame index and beat count on uio.
module dandy_dance
    import dandy_pkg::*;
#(
    parameter int BASE_DIV = 1 << 20
) (
    input logic         clk,
    input logic         rst_n,
    dandy_dance_if.slave bus
);

    logic       run;
    logic       dir;
    logic [2:0] speed;
    pat_e       pattern;
    logic       invert;
    logic       tick;

    logic [2:0] frame_q, frame_d;
    logic       beat_q, beat_d;
    logic [4:0] beat_cnt_q, beat_cnt_d;
    logic [6:0] seg_q, seg_d;

    logic       unused_uio_in;

    assign run     = bus.ui_in[0];
    assign dir     = bus.ui_in[1];
    assign speed   = bus.ui_in[4:2];
    assign pattern = pat_e'(bus.ui_in[6:5]);
    assign invert  = bus.ui_in[7];

    assign unused_uio_in = ^bus.uio_in;

    // ena low freezes the animation exactly like run low.
    dandy_tempo #(
        .BASE_DIV(BASE_DIV)
    ) u_tempo (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(run & bus.ena),
        .speed (speed),
        .tick  (tick)
    );

    // Step frame and beat on tick; segments always follow the current frame.
    always_comb begin
        frame_d    = frame_q;
        beat_d     = beat_q;
        beat_cnt_d = beat_cnt_q;
        if (tick) begin
            frame_d    = dir ? frame_q - 3'd1 : frame_q + 3'd1;
            beat_d     = ~beat_q;
            beat_cnt_d = beat_cnt_q + 5'd1;
        end
        seg_d = seg_lookup(pattern, frame_q) ^ {7{invert}};
    end

    // Animation state and registered segment drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= '0;
            beat_q     <= 1'b0;
            beat_cnt_q <= '0;
            seg_q      <= '0;
        end else begin
            frame_q    <= frame_d;
            beat_q     <= beat_d;
            beat_cnt_q <= beat_cnt_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.uo_out  = {beat_q, seg_q};
    assign bus.uio_out = {beat_cnt_q, frame_q};
    assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_dandy_dance.sv
// Directed bench for dandy_dance with BASE_DIV=16: a table of
// {inputs, clocks, expected outputs} steps plus hand-written reset sequences.
module tb_dandy_dance;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dandy_dance_if bus ();

    dandy_dance #(
        .BASE_DIV(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] ui;
        logic       ena;
        int         clocks;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic [7:0] ui, input logic ena,
                       input int clocks, input logic [7:0] uo, input logic [7:0] uio);
        vec_t v;
        v.name = name; v.ui = ui; v.ena = ena; v.clocks = clocks;
        v.exp_uo = uo; v.exp_uio = uio;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Forward spin, speed 0: one step per 16 clocks; first check lands
        // one clock after the tick so segments have caught up.
        add("fwd_f1",  8'h01, 1'b1, 17, 8'h82, 8'h09);
        add("fwd_f2",  8'h01, 1'b1, 16, 8'h04, 8'h12);
        add("fwd_f3",  8'h01, 1'b1, 16, 8'h88, 8'h1B);
        add("fwd_f4",  8'h01, 1'b1, 16, 8'h10, 8'h24);
        add("fwd_f5",  8'h01, 1'b1, 16, 8'hA0, 8'h2D);
        add("fwd_f6",  8'h01, 1'b1, 16, 8'h01, 8'h36);
        add("fwd_f7",  8'h01, 1'b1, 16, 8'h82, 8'h3F);
        add("fwd_wrap", 8'h01, 1'b1, 16, 8'h01, 8'h40);
        // Partial count (prescaler reaches 6), then hold by run and by ena.
        add("part",    8'h01, 1'b1, 5,   8'h01, 8'h40);
        add("pause",   8'h00, 1'b1, 100, 8'h01, 8'h40);
        add("ena_off", 8'h01, 1'b0, 50,  8'h01, 8'h40);
        add("resume9", 8'h01, 1'b1, 9,   8'h01, 8'h40);
        add("resume10", 8'h01, 1'b1, 1,  8'h81, 8'h49);
        add("resume11", 8'h01, 1'b1, 1,  8'h82, 8'h49);
        // Reach frame 3, then pattern / invert changes while paused.
        add("to_f3",   8'h01, 1'b1, 32, 8'h88, 8'h5B);
        add("pat3",    8'h60, 1'b1, 1,  8'hE3, 8'h5B);
        add("pat3_inv", 8'hE0, 1'b1, 1, 8'h9C, 8'h5B);
        add("pat1",    8'h20, 1'b1, 1,  8'hC0, 8'h5B);
        add("pat2",    8'h40, 1'b1, 1,  8'h86, 8'h5B);
        add("pat2_inv", 8'hC0, 1'b1, 1, 8'hF9, 8'h5B);
        // Reverse at speed 4 (limit 1): one step per clock, 0 wraps to 7.
        add("rev_f2",  8'h13, 1'b1, 1,  8'h08, 8'h62);
        add("rev_f1",  8'h13, 1'b1, 1,  8'h84, 8'h69);
        add("rev_f0",  8'h13, 1'b1, 1,  8'h02, 8'h70);
        add("rev_f7",  8'h13, 1'b1, 1,  8'h81, 8'h7F);
        add("rev_seg7", 8'h12, 1'b1, 1, 8'h82, 8'h7F);
        // Speed 7 clamps to limit 1; 17 steps wrap beat count 31 -> 0.
        add("bc_wrap", 8'h1D, 1'b1, 17, 8'h02, 8'h00);
        add("bc_next", 8'h1D, 1'b1, 1,  8'h81, 8'h09);
        // Count to 10 at speed 0, then speed 2 (limit 4): over-range ticks at once.
        add("cnt10",   8'h01, 1'b1, 10, 8'h82, 8'h09);
        add("overrng", 8'h09, 1'b1, 1,  8'h02, 8'h12);
        add("spd2",    8'h09, 1'b1, 4,  8'h84, 8'h1B);

        // Reset state, checked with no clock edge since assertion.
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'hA5;
        #1;
        check("rst_uo", bus.uo_out, 8'h00);
        check("rst_uio", bus.uio_out, 8'h00);
        check("uio_oe", bus.uio_oe, 8'hFF);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_uo", bus.uo_out, 8'h01);
        check("post_rst_uio", bus.uio_out, 8'h00);

        foreach (vecs[i]) begin
            bus.ena    = vecs[i].ena;
            bus.ui_in  = vecs[i].ui;
            bus.uio_in = 8'($urandom);
            step(vecs[i].clocks);
            check({vecs[i].name, "_uo"}, bus.uo_out, vecs[i].exp_uo);
            check({vecs[i].name, "_uio"}, bus.uio_out, vecs[i].exp_uio);
        end

        // Mid-animation asynchronous reset: outputs clear without a clock.
        bus.ui_in = 8'h01;
        step(3);
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", bus.uo_out, 8'h00);
        check("async_rst_uio", bus.uio_out, 8'h00);
        #1;
        rst_n = 1'b1;
        // Prescaler was cleared too: first step after a full 16 clocks.
        step(1);
        check("rel_uo", bus.uo_out, 8'h01);
        check("rel_uio", bus.uio_out, 8'h00);
        step(14);
        check("rel_pre15_uio", bus.uio_out, 8'h00);
        step(1);
        check("rel_tick_uio", bus.uio_out, 8'h09);
        check("rel_tick_uo", bus.uo_out, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
